// File: rtl/y86_alu_pkg.sv
// Shared opcode encoding and word width for the Y86-64 execute-stage ALU.
package y86_alu_pkg;

    localparam int WORD_W = 64;

    // Encoding matches OPq ifun[1:0]
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_add64.sv
// WIDTH-bit adder with carry-in; reports signed overflow of x + y + cin.
module alu_add64 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_sum;

    assign w_sum = i_x + i_y + {{(WIDTH-1){1'b0}}, i_cin};
    assign o_sum = w_sum;
    // Overflow only when both addends share a sign the sum does not.
    assign o_ovf = (i_x[WIDTH-1] == i_y[WIDTH-1]) && (w_sum[WIDTH-1] != i_x[WIDTH-1]);

endmodule

// File: rtl/y86_alu.sv
// Registered Y86-64 ALU: add/sub/and/xor with OF, and ZF/SF when ALU_FLAGS_EN is defined.
// Without ALU_FLAGS_EN the zf/sf ports are tied to 0.
module y86_alu
    import y86_alu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ans,
    output logic             overflow,
    output logic             zf,
    output logic             sf
);

    logic             w_sub;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_sum_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic [WIDTH-1:0] r_ans;
    logic             r_ovf;

    // Subtract as b + ~a + 1 so add and sub share one carry chain.
    assign w_sub    = (control == ALU_SUB);
    assign w_addend = w_sub ? ~a : a;

    alu_add64 #(.WIDTH(WIDTH)) u_add (
        .i_x   (b),
        .i_y   (w_addend),
        .i_cin (w_sub),
        .o_sum (w_sum),
        .o_ovf (w_sum_ovf)
    );

    always_comb begin
        w_res = w_sum;
        w_ovf = 1'b0;
        case (alu_op_e'(control))
            ALU_ADD, ALU_SUB: begin
                w_res = w_sum;
                w_ovf = w_sum_ovf;
            end
            ALU_AND: w_res = a & b;
            ALU_XOR: w_res = a ^ b;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ans <= '0;
            r_ovf <= 1'b0;
        end else if (en) begin
            r_ans <= w_res;
            r_ovf <= w_ovf;
        end
    end

    assign ans      = r_ans;
    assign overflow = r_ovf;

`ifdef ALU_FLAGS_EN
    logic r_zf;
    logic r_sf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
        end else if (en) begin
            r_zf <= (w_res == '0);
            r_sf <= w_res[WIDTH-1];
        end
    end

    assign zf = r_zf;
    assign sf = r_sf;
`else
    assign zf = 1'b0;
    assign sf = 1'b0;
`endif

endmodule

// File: tb/tb_y86_alu.sv
// Self-checking bench for y86_alu: directed literal checks plus randomized traffic vs a 65-bit arithmetic model.
module tb_y86_alu;

`ifdef ALU_FLAGS_EN
    localparam bit FLG = 1'b1;
`else
    localparam bit FLG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  control = 2'b00;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [63:0] ans;
    logic        overflow, zf, sf;

    int n_cmp = 0;
    int n_bad = 0;

    y86_alu #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .control(control),
        .a(a), .b(b), .ans(ans), .overflow(overflow), .zf(zf), .sf(sf)
    );

    always #5 clk = ~clk;

    // Reference model: exact 65-bit signed result, overflow iff it does not fit in 64 bits.
    logic [63:0] m_ans;
    logic        m_ov;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        logic signed [64:0] sa, sb, full;
        if (!rst_n) begin
            m_ans = '0;
            m_ov = 1'b0;
            m_valid = 1'b1;
        end else if (en && m_valid) begin
            sa = {a[63], a};
            sb = {b[63], b};
            case (control)
                2'b00: begin full = sb + sa; m_ans = full[63:0]; m_ov = (full[64] != full[63]); end
                2'b01: begin full = sb - sa; m_ans = full[63:0]; m_ov = (full[64] != full[63]); end
                2'b10: begin m_ans = a & b; m_ov = 1'b0; end
                default: begin m_ans = a ^ b; m_ov = 1'b0; end
            endcase
        end
    end

    always @(negedge clk) begin
        logic ezf, esf;
        if (m_valid) begin
            ezf = FLG & (m_ans == 64'd0);
            esf = FLG & m_ans[63];
            n_cmp++;
            if (ans !== m_ans || overflow !== m_ov || zf !== ezf || sf !== esf) begin
                n_bad++;
                $display("FAIL model: got ans=%h of=%b zf=%b sf=%b, want ans=%h of=%b zf=%b sf=%b",
                         ans, overflow, zf, sf, m_ans, m_ov, ezf, esf);
            end
        end
    end

    task automatic drive(input logic e, input logic [1:0] c, input logic [63:0] x, input logic [63:0] y);
        en = e; control = c; a = x; b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [63:0] ea, input logic eo, input logic ez, input logic es);
        logic ezf, esf;
        ezf = FLG & ez;
        esf = FLG & es;
        n_cmp++;
        if (ans !== ea || overflow !== eo || zf !== ezf || sf !== esf) begin
            n_bad++;
            $display("FAIL %s: got ans=%h of=%b zf=%b sf=%b, want ans=%h of=%b zf=%b sf=%b",
                     name, ans, overflow, zf, sf, ea, eo, ezf, esf);
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'd0;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'(int'($urandom_range(0, 15)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] v;
        // Reset held two cycles with live operands
        rst_n = 1'b0;
        drive(1'b1, 2'b00, 64'd5, 64'd7);
        drive(1'b1, 2'b00, 64'd5, 64'd7);
        lit("reset", 64'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;

        drive(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        lit("add_ovf", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 2'b01, 64'd5, 64'd5);
        lit("sub_zero", 64'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 2'b01, 64'd1, 64'h8000_0000_0000_0000);
        lit("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 2'b01, 64'd7, 64'd3);
        lit("sub_order", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2'b01, 64'h8000_0000_0000_0000, 64'd0);
        lit("sub_min", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        lit("add_carry", 64'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 2'b10, 64'hF0F0, 64'hFF00);
        lit("and", 64'hF000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 64'h1234, 64'h1234);
        lit("xor_zero", 64'd0, 1'b0, 1'b1, 1'b0);

        // Enable hold
        drive(1'b1, 2'b00, 64'd3, 64'd4);
        lit("add_3_4", 64'd7, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'(i + 1), rnd64(), rnd64());
            lit("hold", 64'd7, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 2'b11, 64'hFF, 64'h0F);
        lit("resume", 64'hF0, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset discards the pending result
        rst_n = 1'b0;
        drive(1'b1, 2'b00, 64'd9, 64'd9);
        lit("mid_reset", 64'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            v = rnd64();
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0) ? v : rnd64(), v);
        end
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 64'd0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
